// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) single-cycle memory arbiter with data priority,
// a fetch starvation limit and a one-cycle read-return owner tag.
module mem_port_arbiter #(
  parameter int unsigned W_CPU      = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [W_CPU-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [W_CPU-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [W_CPU-1:0] d_addr,
  input  logic [W_CPU-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [W_CPU-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [W_CPU-1:0] mem_addr,
  output logic [W_CPU-1:0] mem_wdata,
  input  logic [W_CPU-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Grant: data wins contention unless fetch has been starved for LIM cycles.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if (starve_cnt_q == LIM) if_gnt = 1'b1;
        else                     d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) mem_addr = if_addr;
    else if (d_gnt) mem_addr = d_addr;
    if (if_gnt || d_gnt) mem_wdata = d_wdata;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) starve_cnt_d = '0;
    else if (starve_cnt_q < LIM) starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) owner_d = OWN_IF;
    else if (d_gnt && !d_we) owner_d = OWN_D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Returning reads are dropped while reset is held.
  assign if_rvalid = (owner_q == OWN_IF) && !rst;
  assign d_rvalid  = (owner_q == OWN_D) && !rst;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, lone grants, writes,
// interleaved reads, contention/starvation and reset during a read.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.W_CPU(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    logic exp_if;
    logic prev_if;

    rst = 1'b1; mem_rdata = '0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h30;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt",  32'(d_gnt),  32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);

    // Lone fetch read right after reset release
    rst = 1'b0; drive_idle(); if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("if_gnt_first", 32'(if_gnt), 32'd1);
    chk("d_gnt_first",  32'(d_gnt),  32'd0);
    chk("mem_en_first", 32'(mem_en), 32'd1);
    chk("mem_we_first", 32'(mem_we), 32'd0);
    chk("mem_addr_first", mem_addr, 32'h40);
    next_cycle();
    drive_idle(); mem_rdata = 32'h1111_2222;
    #1;
    chk("if_rvalid_first", 32'(if_rvalid), 32'd1);
    chk("if_rdata_first", if_rdata, 32'h1111_2222);
    chk("d_rvalid_first", 32'(d_rvalid), 32'd0);
    chk("d_rdata_zero", d_rdata, 32'h0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    chk("idle_mem_wdata", mem_wdata, 32'h0);
    next_cycle();
    chk("if_rvalid_once", 32'(if_rvalid), 32'd0);

    // Data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_d_gnt", 32'(d_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h100);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    drive_idle(); mem_rdata = 32'h5555_5555;
    #1;
    chk("wr_no_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("wr_no_if_rvalid", 32'(if_rvalid), 32'd0);

    // Interleaved reads IF@0, D@0x200, IF@4
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("il0_if_gnt", 32'(if_gnt), 32'd1);
    chk("il0_addr", mem_addr, 32'h0);
    next_cycle();
    drive_idle(); d_req = 1'b1; d_addr = 32'h200; mem_rdata = 32'hA1A1_A1A1;
    #1;
    chk("il1_d_gnt", 32'(d_gnt), 32'd1);
    chk("il1_addr", mem_addr, 32'h200);
    chk("il1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("il1_if_rdata", if_rdata, 32'hA1A1_A1A1);
    next_cycle();
    drive_idle(); if_req = 1'b1; if_addr = 32'h4; mem_rdata = 32'hA2A2_A2A2;
    #1;
    chk("il2_if_gnt", 32'(if_gnt), 32'd1);
    chk("il2_addr", mem_addr, 32'h4);
    chk("il2_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("il2_d_rdata", d_rdata, 32'hA2A2_A2A2);
    chk("il2_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("il2_if_rdata", if_rdata, 32'h0);
    next_cycle();
    drive_idle(); mem_rdata = 32'hA3A3_A3A3;
    #1;
    chk("il3_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("il3_if_rdata", if_rdata, 32'hA3A3_A3A3);
    chk("il3_d_rvalid", 32'(d_rvalid), 32'd0);

    // Continuous contention: 4 data grants then 1 fetch grant, repeating
    prev_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = 32'h1000 + 32'(i * 4); d_addr = 32'h2000 + 32'(i * 4);
      mem_rdata = 32'hC000_0000 + 32'(i);
      #1;
      exp_if = ((i % 5) == 4);
      chk($sformatf("ct%0d_if_gnt", i), 32'(if_gnt), 32'(exp_if));
      chk($sformatf("ct%0d_d_gnt", i), 32'(d_gnt), 32'(!exp_if));
      chk($sformatf("ct%0d_addr", i), mem_addr, exp_if ? if_addr : d_addr);
      if (i > 0) begin
        chk($sformatf("ct%0d_if_rvalid", i), 32'(if_rvalid), 32'(prev_if));
        chk($sformatf("ct%0d_d_rvalid", i), 32'(d_rvalid), 32'(!prev_if));
        chk($sformatf("ct%0d_rdata", i), prev_if ? if_rdata : d_rdata, mem_rdata);
      end
      prev_if = exp_if;
    end
    next_cycle();
    drive_idle(); mem_rdata = 32'hC0DE_0009;
    #1;
    chk("ct_tail_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("ct_tail_if_rdata", if_rdata, 32'hC0DE_0009);

    // Starvation counter clears when fetch drops its request
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h300; d_addr = 32'h400;
      #1;
      chk($sformatf("sc%0d_d_gnt", i), 32'(d_gnt), 32'd1);
    end
    next_cycle();
    chk("sc_cnt3", 32'(dut.starve_cnt_q), 32'd3);
    if_req = 1'b0;
    #1;
    chk("sc_drop_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    chk("sc_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk($sformatf("sc2_%0d_if_gnt", i), 32'(if_gnt), 32'(i == 4));
      chk($sformatf("sc2_%0d_d_gnt", i), 32'(d_gnt), 32'(i != 4));
    end

    // Reset arriving while a fetch read is in flight
    next_cycle();
    drive_idle(); if_req = 1'b1; if_addr = 32'h500;
    #1;
    chk("rm_if_gnt", 32'(if_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rm_if_rvalid_n1", 32'(if_rvalid), 32'd0);
    chk("rm_if_rdata_n1", if_rdata, 32'h0);
    chk("rm_if_gnt_rst", 32'(if_gnt), 32'd0);
    chk("rm_mem_en_rst", 32'(mem_en), 32'd0);
    next_cycle();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h600;
    #1;
    chk("rm_if_rvalid_n2", 32'(if_rvalid), 32'd0);
    chk("rm_starve_zero", 32'(dut.starve_cnt_q), 32'd0);
    chk("rm_first_gnt", 32'(if_gnt), 32'd1);
    chk("rm_first_addr", mem_addr, 32'h600);
    next_cycle();
    drive_idle(); mem_rdata = 32'h6666_0000;
    #1;
    chk("rm_post_rvalid", 32'(if_rvalid), 32'd1);
    chk("rm_post_rdata", if_rdata, 32'h6666_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
